reg_dest_scoreboard: RTL
========================

Name: reg_dest_scoreboard

Overview:
Parametrised successor to the register-file write-enable decoder. Decodes a writeback destination address into a registered one-hot write-enable bus for the register file. Also keeps a per-register pending-write scoreboard, so issue logic can stall on a destination that still has a write outstanding. Sits between instruction fetch/decode (issue side) and the register file (writeback side).

Parameters:
ADDR_W, 4, destination address width (instruction field width).
NUM_REGS, 16, number of registers; legal range 2..2**ADDR_W; addresses >= NUM_REGS are out of range.
CNT_W, $clog2(NUM_REGS+1), width of pending_cnt (derived, not overridden).

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  synchronous, active-high reset.
issue_valid  in  1  decode stage requests to reserve destination issue_addr.
issue_addr  in  ADDR_W  destination register of the issuing instruction.
issue_ready  out  1  combinational; reservation is accepted this cycle when high.
wb_valid  in  1  writeback of register wb_addr this cycle.
wb_addr  in  ADDR_W  writeback destination address.
wr_en  out  NUM_REGS  registered one-hot register-file write enable.
pending  out  NUM_REGS  registered scoreboard, bit i = write to reg i outstanding.
pending_cnt  out  CNT_W  registered population count of pending.
wb_err  out  1  registered one-cycle error pulse.

Behaviour:
- Reset (synchronous, active-high) values: wr_en=0, pending=0, pending_cnt=0, wb_err=0.
- Reset applied mid-operation clears all reservations on that edge. issue_ready is still computed combinationally during reset, but any handshake in a reset cycle is discarded.
- Never drive Z or X. Idle and out-of-range decodes produce all-zero wr_en.
- wr_en latency is 1 cycle:
  - wb_valid=1 with wb_addr<NUM_REGS in cycle N -> wr_en = 1<<wb_addr in cycle N+1.
  - Otherwise wr_en=0 in cycle N+1.
  - At most one wr_en bit is ever set.
- issue_ready = issue_addr<NUM_REGS AND pending[issue_addr]==0. It is independent of issue_valid.
- Issue handshake: issue_valid & issue_ready at an edge sets pending[issue_addr].
- Writeback: wb_valid with an in-range wb_addr clears pending[wb_addr] at the edge.
- Same-address issue and writeback in one cycle: no bypass. If the bit is pending, issue_ready is 0, the writeback clears the bit, and the issue retries next cycle.
- Different-address issue and writeback in one cycle: both take effect. pending_cnt is unchanged.
- pending_cnt next value:
  - +1 on a lone issue handshake.
  - -1 on a lone clear of a set bit.
  - Unchanged on both or neither.
  - Must always equal popcount(pending); never wraps (max NUM_REGS).
- wb_err pulses high in cycle N+1 if, in cycle N, wb_valid=1 and either:
  - wb_addr>=NUM_REGS, or
  - pending[wb_addr]==0 (writeback without a reservation).
- An unreserved in-range writeback still asserts wr_en; the register file is written. The error is report-only.
- An out-of-range issue_addr is never ready and never sets a bit. Issue logic holding issue_valid on it stalls indefinitely; that is the intended behaviour.

Optional Feature:
Macro: REG_ZERO_HARDWIRED_EN.

With the macro defined, register 0 is hardwired zero:
- wr_en[0] is forced 0.
- pending[0] stays 0.
- issue to address 0 is always ready and never counted.
- A writeback to address 0 never raises wb_err.

Without the macro, register 0 behaves like every other register.

Test Plan:
- Reset, then issue_valid=1 addr=5 for one cycle -> issue_ready=1, pending=0x0020, pending_cnt=1. Then wb_valid=1 addr=5 -> next cycle wr_en=0x0020, pending=0, pending_cnt=0, wb_err=0.
- Reserve addr 3, then issue addr 3 again -> issue_ready=0, pending stays 0x0008. Then same-cycle wb addr 3 + issue addr 3 -> pending=0 after the edge; issue accepted on the following cycle, pending=0x0008.
- Same-cycle issue addr 2 and wb addr 7 with 7 pending -> pending bit 2 set, bit 7 cleared, pending_cnt unchanged, wr_en=0x0080 next cycle.
- ADDR_W=4, NUM_REGS=12: wb addr 13 -> wr_en=0, wb_err=1 for one cycle. Issue addr 14 -> issue_ready=0. wb addr 4 with nothing pending -> wr_en=0x010, wb_err=1.
- Reserve all 16 registers -> pending=0xFFFF, pending_cnt=16. Assert reset for one cycle with issue_valid=1 -> pending=0, pending_cnt=0, wr_en=0.
- Run with REG_ZERO_HARDWIRED_EN defined: issue addr 0 -> ready, pending=0. wb addr 0 -> wr_en=0, wb_err=0. Rerun without the macro -> pending=0x0001 and wr_en=0x0001.

Source files
------------

// File: rtl/reg_dest_scoreboard.sv
// reg_dest_scoreboard
// Decodes the writeback destination into a registered one-hot register-file
// write enable and tracks a per-register pending-write scoreboard so the issue
// stage can stall on a destination that still has a write outstanding.
// Optional build macro: REG_ZERO_HARDWIRED_EN (register 0 hardwired to zero:
// never written, never reserved, always issuable, never flagged on writeback).
module reg_dest_scoreboard #(
  parameter  int ADDR_W   = 4,
  parameter  int NUM_REGS = 16,
  localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    pending_cnt,
  output logic                wb_err
);

  // Registers that may actually be written or reserved. With register 0
  // hardwired, its bit is masked out of every write enable and reservation.
`ifdef REG_ZERO_HARDWIRED_EN
  localparam logic [NUM_REGS-1:0] WRITABLE = {{(NUM_REGS-1){1'b1}}, 1'b0};
`else
  localparam logic [NUM_REGS-1:0] WRITABLE = {NUM_REGS{1'b1}};
`endif

  logic [NUM_REGS-1:0] issue_dec;   // one-hot of issue_addr, zero if out of range
  logic [NUM_REGS-1:0] wb_dec;      // one-hot of wb_addr, zero if out of range
  logic                issue_fire;  // reservation handshake this cycle
  logic [NUM_REGS-1:0] set_vec;     // bit being reserved this cycle
  logic [NUM_REGS-1:0] clr_vec;     // bit being released this cycle
  logic                cnt_inc;
  logic                cnt_dec;
  logic                wb_err_next;

  // Address decode: an out-of-range address simply matches no register.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no path leaves it unassigned (no latch).
    issue_dec = '0;
    wb_dec    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      issue_dec[i] = (issue_addr == ADDR_W'(i));
      wb_dec[i]    = (wb_addr == ADDR_W'(i));
    end
  end

  // Ready means in range and not already reserved; it ignores issue_valid.
  // A hardwired register 0 is never pending, so it always reads as ready.
  assign issue_ready = (|issue_dec) & ~(|(issue_dec & pending));
  assign issue_fire  = issue_valid & issue_ready;

  // Scoreboard update vectors. No same-cycle bypass: a pending destination
  // is not ready, so the writeback clears it and the issue retries later.
  assign set_vec = issue_fire ? (issue_dec & WRITABLE) : '0;
  assign clr_vec = wb_valid   ? wb_dec                 : '0;

  // The count moves only when the population actually changes, so it
  // always equals popcount(pending) and cannot wrap.
  assign cnt_inc = |set_vec;
  assign cnt_dec = |(clr_vec & pending);

  // Error on out-of-range or unreserved writeback, except hardwired reg 0.
  assign wb_err_next = wb_valid & ~(|(wb_dec & pending)) & ~(|(wb_dec & ~WRITABLE));

  // Registered state: write-enable pulse, scoreboard, count and error pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_en       <= '0;
      pending     <= '0;
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      wr_en       <= wb_valid ? (wb_dec & WRITABLE) : '0;
      pending     <= (pending & ~clr_vec) | set_vec;
      pending_cnt <= pending_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
      wb_err      <= wb_err_next;
    end
  end

endmodule
